perf_event_monitor: RTL and testbench

Parametrised, synthesizable performance monitor for the pipelined CPU. It counts run cycles and up to NUM_EVT single-bit pipeline events (stall, flush, branch taken, retire, …) in saturating counters, and halts counting at a programmable cycle limit. On request it snapshots all counters and streams them out over a valid/ready port. It sits beside the CPU top, fed by hazard-detection and control strobes. It replaces per-signal counting in simulation-only benches with hardware that survives synthesis.

---
 rtl/perf_pkg.sv | 38 +++
 rtl/perf_event_monitor_sat_counter.sv | 51 +++++
 rtl/perf_event_monitor.sv | 112 +++++++++++
 tb/tb_perf_event_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types, event indices and the saturating-increment rule for the
// performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } run_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_SEND = 1'b1
    } dump_state_e;

    localparam int EVT_STALL  = 0;
    localparam int EVT_FLUSH  = 1;
    localparam int EVT_BRANCH = 2;
    localparam int EVT_RETIRE = 3;

    // Widest supported counter; narrower counters pass their own ceiling.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic             ovf;
        logic [SAT_W-1:0] value;
    } sat_res_t;

    function automatic sat_res_t sat_inc(input logic [SAT_W-1:0] value,
                                         input logic             inc,
                                         input logic [SAT_W-1:0] max_val);
        sat_res_t res;
        res.ovf   = inc && (value == max_val);
        res.value = res.ovf ? value : value + {{(SAT_W-1){1'b0}}, inc};
        return res;
    endfunction

endpackage

// File: rtl/perf_event_monitor_sat_counter.sv
// Saturating counter with sticky overflow flag and synchronous clear.
module sat_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    localparam logic [SAT_W-1:0] MAX_VAL = {SAT_W{1'b1}} >> (SAT_W - CNT_W);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    sat_res_t         res;
    logic [SAT_W-1:0] unused_value;

    assign unused_value = res.value;

    always_comb begin
        res     = sat_inc(SAT_W'(count_q), inc_i, MAX_VAL);
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (enable_i) begin
            count_d = res.value[CNT_W-1:0];
            ovf_d   = ovf_q | res.ovf;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// Cycle/event performance monitor: saturating counters, optional cycle limit,
// and a snapshot streamed out over a valid/ready port.
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int          NUM_EVT    = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    input  logic                          clear_i,
    input  logic [NUM_EVT-1:0]            evt_i,
    input  logic                          snap_req_i,
    input  logic                          out_ready_i,
    output logic                          out_valid_o,
    output logic [$clog2(NUM_EVT+2)-1:0]  out_idx_o,
    output logic [CNT_W-1:0]              out_data_o,
    output logic                          out_last_o,
    output logic [NUM_EVT:0]              ovf_o,
    output logic                          halt_o,
    output logic                          busy_o
);

    localparam int               IDX_W     = $clog2(NUM_EVT + 2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_EVT);
    localparam bit               LIMIT_EN  = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] LIMIT_PRE = LIMIT_EN ? CNT_W'(MAX_CYCLES - 1) : '0;

    run_state_e       run_q;
    dump_state_e      dump_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] shadow_q [NUM_EVT+1];
    logic [CNT_W-1:0] cnt      [NUM_EVT+1];
    logic [NUM_EVT:0] inc_vec;
    logic             counting;

    assign counting = (run_q == RUN);
    // Counter 0 is the run-cycle counter, always incremented while running.
    assign inc_vec  = {evt_i, 1'b1};

    generate
        for (genvar gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk_i    (clk_i),
                .rst_n_i  (rst_n_i),
                .clear_i  (clear_i),
                .enable_i (counting),
                .inc_i    (inc_vec[gi]),
                .count_o  (cnt[gi]),
                .ovf_o    (ovf_o[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q <= IDLE;
        end else if (clear_i) begin
            run_q <= IDLE;
        end else begin
            case (run_q)
                IDLE:    if (start_i) run_q <= RUN;
                RUN: begin
                    // The limit wins over start_i dropping on the same edge.
                    if (LIMIT_EN && cnt[0] == LIMIT_PRE) run_q <= HALT;
                    else if (!start_i)                   run_q <= IDLE;
                end
                HALT:    run_q <= HALT;
                default: run_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dump_q <= D_IDLE;
            idx_q  <= '0;
            for (int i = 0; i <= NUM_EVT; i++) shadow_q[i] <= '0;
        end else begin
            case (dump_q)
                D_IDLE: begin
                    if (snap_req_i) begin
                        for (int i = 0; i <= NUM_EVT; i++) shadow_q[i] <= cnt[i];
                        idx_q  <= '0;
                        dump_q <= D_SEND;
                    end
                end
                D_SEND: begin
                    if (out_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q  <= '0;
                            dump_q <= D_IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: dump_q <= D_IDLE;
            endcase
        end
    end

    assign out_valid_o = (dump_q == D_SEND);
    assign busy_o      = out_valid_o;
    assign out_idx_o   = idx_q;
    assign out_data_o  = out_valid_o ? shadow_q[idx_q] : '0;
    assign out_last_o  = out_valid_o && (idx_q == LAST_IDX);
    assign halt_o      = (run_q == HALT);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench: expected snapshot words are queued at request time and a
// monitor per DUT pops and compares them on each output handshake.
module tb_perf_event_monitor;
    import perf_pkg::*;

    localparam int NE = 4;
    localparam int CW = 8;

    typedef struct {
        logic [2:0]    idx;
        logic [CW-1:0] data;
    } word_t;

    logic clk, rst_n, ready, evt_dummy;
    logic start1, clear1, snap1, start2, clear2, snap2;
    logic [NE-1:0] evt;

    logic          valid1, last1, halt1, busy1;
    logic [2:0]    idx1;
    logic [CW-1:0] data1;
    logic [NE:0]   ovf1;
    logic          valid2, last2, halt2, busy2;
    logic [2:0]    idx2;
    logic [CW-1:0] data2;
    logic [NE:0]   ovf2;

    word_t q1[$];
    word_t q2[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    perf_event_monitor #(.NUM_EVT(NE), .CNT_W(CW), .MAX_CYCLES(0)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .clear_i(clear1),
        .evt_i(evt), .snap_req_i(snap1), .out_ready_i(ready),
        .out_valid_o(valid1), .out_idx_o(idx1), .out_data_o(data1),
        .out_last_o(last1), .ovf_o(ovf1), .halt_o(halt1), .busy_o(busy1)
    );

    perf_event_monitor #(.NUM_EVT(NE), .CNT_W(CW), .MAX_CYCLES(10)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .clear_i(clear2),
        .evt_i(evt), .snap_req_i(snap2), .out_ready_i(ready),
        .out_valid_o(valid2), .out_idx_o(idx2), .out_data_o(data2),
        .out_last_o(last2), .ovf_o(ovf2), .halt_o(halt2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
            $display("check %-22s actual=%0d expected=%0d ok", name, act, exp);
        end else begin
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int which, input int c0, input int c1, input int c2, input int c3, input int c4);
        int    vals[5];
        word_t w;
        vals = '{c0, c1, c2, c3, c4};
        for (int i = 0; i < 5; i++) begin
            w.idx  = 3'(i);
            w.data = CW'(vals[i]);
            if (which == 1) q1.push_back(w);
            else            q2.push_back(w);
        end
    endtask

    task automatic drain(input int which, input string name);
        int n = 0;
        if (which == 1) begin
            while ((busy1 || q1.size() != 0) && n < 60) begin step(); n++; end
            check({name, "_drained"}, longint'(busy1 || q1.size() != 0), 0);
        end else begin
            while ((busy2 || q2.size() != 0) && n < 60) begin step(); n++; end
            check({name, "_drained"}, longint'(busy2 || q2.size() != 0), 0);
        end
    endtask

    // Monitor for dut1: hold-stability while stalled, pop-and-compare on handshake.
    initial begin : mon1
        logic          held;
        logic [2:0]    hidx;
        logic [CW-1:0] hdata;
        word_t         w;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else if (valid1) begin
                if (held) begin
                    check("d1_hold_idx", idx1, hidx);
                    check("d1_hold_data", data1, hdata);
                end
                if (ready) begin
                    held = 1'b0;
                    if (q1.size() == 0) begin
                        total_cnt++;
                        $display("FAIL d1_unexpected_word actual=idx%0d/data%0d required=no word", idx1, data1);
                    end else begin
                        w = q1.pop_front();
                        check("d1_idx", idx1, w.idx);
                        check("d1_data", data1, w.data);
                        check("d1_last", last1, longint'(w.idx == 3'(NE)));
                    end
                end else begin
                    held  = 1'b1;
                    hidx  = idx1;
                    hdata = data1;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin : mon2
        word_t w;
        forever begin
            @(negedge clk);
            if (rst_n && valid2 && ready) begin
                if (q2.size() == 0) begin
                    total_cnt++;
                    $display("FAIL d2_unexpected_word actual=idx%0d/data%0d required=no word", idx2, data2);
                end else begin
                    w = q2.pop_front();
                    check("d2_idx", idx2, w.idx);
                    check("d2_data", data2, w.data);
                    check("d2_last", last2, longint'(w.idx == 3'(NE)));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        evt_dummy = 1'b0;
        rst_n = 1'b0; ready = 1'b1; evt = '0;
        start1 = 1'b0; clear1 = 1'b0; snap1 = 1'b0;
        start2 = 1'b0; clear2 = 1'b0; snap2 = 1'b0;
        #12;
        check("rst_valid", valid1, 0);
        check("rst_busy", busy1, 0);
        check("rst_halt", halt1, 0);
        check("rst_ovf", ovf1, 0);
        check("rst_idx", idx1, 0);
        check("rst_data", data1, 0);
        check("rst_last", last1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic count: 10 run cycles, 3 stall events.
        start1 = 1'b1; evt = '0; step();
        for (int i = 0; i < 9; i++) begin
            evt = (i < 3) ? NE'(1 << EVT_STALL) : '0;
            step();
        end
        start1 = 1'b0; evt = '0; step();
        push(1, 10, 3, 0, 0, 0);
        snap1 = 1'b1; step(); snap1 = 1'b0;
        check("stream_start", valid1, 1);
        repeat (4) step();
        check("stream_len4", valid1, 1);
        step();
        check("stream_end", valid1, 0);
        drain(1, "basic");

        // Backpressure with a ready pattern 1,0,0 and an ignored mid-stream request.
        clear1 = 1'b1; step(); clear1 = 1'b0;
        start1 = 1'b1; evt = '0; step();
        evt = 4'b0001; step();
        evt = 4'b0011; step();
        evt = 4'b0111; step();
        evt = 4'b1111; step();
        start1 = 1'b0; evt = '0; step();
        push(1, 5, 4, 3, 2, 1);
        snap1 = 1'b1; step(); snap1 = 1'b0;
        for (int k = 0; k < 40 && busy1; k++) begin
            ready = (k % 3 == 0);
            snap1 = (k == 4);
            step();
        end
        snap1 = 1'b0; ready = 1'b1;
        drain(1, "backpressure");

        // Clear priority, and a clear during a stalled dump.
        clear1 = 1'b1; step(); clear1 = 1'b0;
        start1 = 1'b1; evt = '0; step();
        evt = 4'hF; step(); step();
        start1 = 1'b0; evt = '0; step();
        push(1, 3, 2, 2, 2, 2);
        ready = 1'b0;
        snap1 = 1'b1; step(); snap1 = 1'b0;
        step();
        clear1 = 1'b1; start1 = 1'b1; evt = 4'hF; step();
        clear1 = 1'b0; start1 = 1'b0; evt = '0;
        check("clr_ovf", ovf1, 0);
        check("clr_busy_kept", busy1, 1);
        step();
        ready = 1'b1;
        drain(1, "clr_stream");
        push(1, 0, 0, 0, 0, 0);
        snap1 = 1'b1; step(); snap1 = 1'b0;
        drain(1, "clr_zero");

        // Cycle limit on the second instance.
        clear2 = 1'b1; step(); clear2 = 1'b0;
        start2 = 1'b1; evt = '0; step();
        evt = 4'hF;
        repeat (9) step();
        check("halt_before_limit", halt2, 0);
        step();
        check("halt_at_limit", halt2, 1);
        repeat (5) step();
        start2 = 1'b0; step();
        evt = '0;
        check("halt_sticky", halt2, 1);
        push(2, 10, 10, 10, 10, 10);
        snap2 = 1'b1; step(); snap2 = 1'b0;
        drain(2, "limit");
        clear2 = 1'b1; step(); clear2 = 1'b0;
        check("halt_cleared", halt2, 0);
        push(2, 0, 0, 0, 0, 0);
        snap2 = 1'b1; step(); snap2 = 1'b0;
        drain(2, "limit_clr");

        // Saturation: 300 run cycles with the flush event high (cycle counter saturates too).
        clear1 = 1'b1; step(); clear1 = 1'b0;
        start1 = 1'b1; evt = '0; step();
        evt = NE'(1 << EVT_FLUSH);
        repeat (255) step();
        check("ovf_before_sat", ovf1, 0);
        step();
        check("ovf_at_sat", ovf1, 5'b00101);
        repeat (43) step();
        start1 = 1'b0; evt = '0; step();
        check("ovf_sticky", ovf1, 5'b00101);
        push(1, 255, 0, 255, 0, 0);
        snap1 = 1'b1; step(); snap1 = 1'b0;
        drain(1, "sat");

        // Asynchronous reset in the middle of a stalled stream.
        ready = 1'b0;
        push(1, 255, 0, 255, 0, 0);
        snap1 = 1'b1; step(); snap1 = 1'b0;
        step();
        check("pre_rst_valid", valid1, 1);
        #2;
        q1.delete();
        rst_n = 1'b0;
        #1;
        check("arst_valid", valid1, 0);
        check("arst_busy", busy1, 0);
        check("arst_ovf", ovf1, 0);
        check("arst_data", data1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ready = 1'b1;
        push(1, 0, 0, 0, 0, 0);
        snap1 = 1'b1; step(); snap1 = 1'b0;
        drain(1, "arst_zero");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
